// File: rtl/parking_gate_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared types for the parking gate arbiter:
//   gate_state_t - arbiter FSM states
//   lane_t       - lane encoding used for the round-robin last_served flag
//   timer_width  - width of the shared gate timer for given delay parameters
// -----------------------------------------------------------------------------
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_ENTRY = 2'd1,
        GRANT_EXIT  = 2'd2,
        CLOSING     = 2'd3
    } gate_state_t;

    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_t;

    // The timer is loaded with (delay - 1), so $clog2 of the larger delay
    // always holds the load value; keep at least one bit.
    function automatic int timer_width(input int gate_timeout, input int close_delay);
        int m;
        m = (gate_timeout > close_delay) ? gate_timeout : close_delay;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage : parking_pkg

// File: rtl/parking_gate_arbiter_if.sv
// -----------------------------------------------------------------------------
// parking_gate_arbiter_if
// Bundles the lane sensor inputs and the gate/occupancy outputs.
//   master : sensor front end side (drives sensors and pass pulses)
//   slave  : arbiter side (drives gate, grants, occupancy, lot_full, alarm)
// Signals:
//   entry_sensor / exit_sensor  - debounced lane presence levels
//   entry_passed / exit_passed  - one-cycle "vehicle cleared" pulses
//   gate_open                   - barrier open command
//   entry_grant / exit_grant    - lane currently owning the gate
//   occupancy [CNT_W]           - current vehicle count
//   lot_full                    - occupancy equals capacity
//   timeout_alarm               - one-cycle pulse when a grant expires
// -----------------------------------------------------------------------------
interface parking_gate_arbiter_if #(
    parameter int CNT_W = 5
);
    logic             entry_sensor;
    logic             exit_sensor;
    logic             entry_passed;
    logic             exit_passed;
    logic             gate_open;
    logic             entry_grant;
    logic             exit_grant;
    logic [CNT_W-1:0] occupancy;
    logic             lot_full;
    logic             timeout_alarm;

    modport master (
        output entry_sensor, exit_sensor, entry_passed, exit_passed,
        input  gate_open, entry_grant, exit_grant, occupancy, lot_full, timeout_alarm
    );

    modport slave (
        input  entry_sensor, exit_sensor, entry_passed, exit_passed,
        output gate_open, entry_grant, exit_grant, occupancy, lot_full, timeout_alarm
    );
endinterface : parking_gate_arbiter_if

// File: rtl/parking_gate_arbiter_gate_timer.sv
// -----------------------------------------------------------------------------
// gate_timer
// Loadable down-counter shared by the grant timeout and the CLOSING hold.
// Ports:
//   clk        - system clock
//   reset_n    - synchronous reset, active low
//   load_i     - load load_val_i into the counter (has priority over en_i)
//   load_val_i - value to load; done_o rises load_val_i cycles after the load
//   en_i       - count down by one per cycle, stopping at zero
//   done_o     - counter is zero
// -----------------------------------------------------------------------------
module gate_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);
    logic [W-1:0] count_q;

    // NOTE: reset is synchronous, so it is tested inside the clocked block
    // rather than appearing in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done_o = (count_q == '0);

endmodule : gate_timer

// File: rtl/parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// parking_gate_arbiter
// Sequences the shared barrier gate between the entry and exit lanes, keeps
// the lot occupancy count, blocks entry when the lot is full and recovers
// from vehicles that never pass.
// Ports:
//   clk      - system clock
//   reset_n  - synchronous reset, active low
//   bus      - parking_gate_arbiter_if.slave (sensors in; gate, grants,
//              occupancy, lot_full, timeout_alarm out)
// Configuration macro:
//   GATE_TIMEOUT_EN - when defined, a grant expires after GATE_TIMEOUT cycles
//                     without a pass and raises timeout_alarm; when undefined,
//                     a grant is held until the lane's pass pulse and
//                     timeout_alarm stays 0.
// -----------------------------------------------------------------------------
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY     = 16,
    parameter int CNT_W        = 5,
    parameter int GATE_TIMEOUT = 5000,
    parameter int CLOSE_DELAY  = 100
) (
    input logic                   clk,
    input logic                   reset_n,
    parking_gate_arbiter_if.slave bus
);
    localparam int TW = timer_width(GATE_TIMEOUT, CLOSE_DELAY);

    gate_state_t      state_q, state_d;
    lane_t            last_served_q, last_served_d;
    logic [CNT_W-1:0] occupancy_q, occupancy_d;
    logic             alarm_d;

    // Registered outputs, all decoded from the next state.
    logic entry_grant_q;
    logic exit_grant_q;
    logic gate_open_q;
    logic lot_full_q;
    logic alarm_q;

    logic          entry_req;
    logic          exit_req;
    logic          timer_load;
    logic [TW-1:0] timer_load_val;
    logic          timer_done;

    assign entry_req = bus.entry_sensor && !lot_full_q;
    assign exit_req  = bus.exit_sensor && (occupancy_q != '0);

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        occupancy_d   = occupancy_q;
        alarm_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (entry_req && exit_req) begin
                    // Tie: serve the lane that did not win the previous tie.
                    if (last_served_q == LANE_EXIT) begin
                        state_d       = GRANT_ENTRY;
                        last_served_d = LANE_ENTRY;
                    end else begin
                        state_d       = GRANT_EXIT;
                        last_served_d = LANE_EXIT;
                    end
                end else if (entry_req) begin
                    state_d = GRANT_ENTRY;
                end else if (exit_req) begin
                    state_d = GRANT_EXIT;
                end
            end

            GRANT_ENTRY: begin
                // A pass takes priority over an expiring timer.
                if (bus.entry_passed) begin
                    if (occupancy_q != CNT_W'(CAPACITY)) begin
                        occupancy_d = occupancy_q + CNT_W'(1);
                    end
                    state_d = CLOSING;
                end
`ifdef GATE_TIMEOUT_EN
                else if (timer_done) begin
                    alarm_d = 1'b1;
                    state_d = CLOSING;
                end
`endif
            end

            GRANT_EXIT: begin
                if (bus.exit_passed) begin
                    if (occupancy_q != '0) begin
                        occupancy_d = occupancy_q - CNT_W'(1);
                    end
                    state_d = CLOSING;
                end
`ifdef GATE_TIMEOUT_EN
                else if (timer_done) begin
                    alarm_d = 1'b1;
                    state_d = CLOSING;
                end
`endif
            end

            CLOSING: begin
                if (timer_done) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // The timer restarts on every state change. Loading (delay - 1) makes
    // done visible in the last cycle of the state, so the FSM leaves after
    // exactly 'delay' cycles.
    always_comb begin
        timer_load     = (state_d != state_q);
        timer_load_val = '0;
        case (state_d)
            GRANT_ENTRY,
            GRANT_EXIT: timer_load_val = TW'(GATE_TIMEOUT - 1);
            CLOSING:    timer_load_val = TW'(CLOSE_DELAY - 1);
            default:    timer_load_val = '0;
        endcase
    end

    gate_timer #(
        .W (TW)
    ) u_gate_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .en_i       (state_q != IDLE),
        .done_o     (timer_done)
    );

    // NOTE: state is updated with non-blocking assignments so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_served_q <= LANE_EXIT;
            occupancy_q   <= '0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            gate_open_q   <= 1'b0;
            lot_full_q    <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            occupancy_q   <= occupancy_d;
            entry_grant_q <= (state_d == GRANT_ENTRY);
            exit_grant_q  <= (state_d == GRANT_EXIT);
            gate_open_q   <= (state_d == GRANT_ENTRY) || (state_d == GRANT_EXIT);
            lot_full_q    <= (occupancy_d == CNT_W'(CAPACITY));
            alarm_q       <= alarm_d;
        end
    end

    assign bus.gate_open     = gate_open_q;
    assign bus.entry_grant   = entry_grant_q;
    assign bus.exit_grant    = exit_grant_q;
    assign bus.occupancy     = occupancy_q;
    assign bus.lot_full      = lot_full_q;
    assign bus.timeout_alarm = alarm_q;

endmodule : parking_gate_arbiter
